// File: rtl/c4_pkg.sv
// Shared constants, state encoding and direction helpers for the Connect-4 board engine.
package c4_pkg;

   localparam int ROWS   = 6;
   localparam int COLS   = 7;
   localparam int NCELLS = 42;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b01;
   localparam logic [1:0] CELL_P2    = 2'b10;
   localparam logic [1:0] WIN_NONE   = 2'b00;
   localparam logic [1:0] WIN_DRAW   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_FIND, S_PLACE, S_CHECK, S_HOLD, S_OVER, S_CLEAR, S_CLR_HOLD
   } state_t;

   typedef logic signed [3:0] coord_t;

   // Directions 0..3: horizontal, vertical, diagonal '/', diagonal '\' (row 0 is the top row)
   function automatic coord_t dir_dr(input logic [1:0] d);
      case (d)
         2'd0:    return 4'sd0;
         2'd1:    return 4'sd1;
         2'd2:    return -4'sd1;
         default: return 4'sd1;
      endcase
   endfunction

   function automatic coord_t dir_dc(input logic [1:0] d);
      case (d)
         2'd0:    return 4'sd1;
         2'd1:    return 4'sd0;
         default: return 4'sd1;
      endcase
   endfunction

   function automatic logic on_board(input coord_t r, input coord_t c);
      return (r >= 4'sd0) && (r < 4'sd6) && (c >= 4'sd0) && (c < 4'sd7);
   endfunction

   function automatic logic [5:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
      return {3'b000, r} * 6'd7 + {3'b000, c};
   endfunction

endpackage

// File: rtl/c4_board_engine_if.sv
// Player-command and board/status bundle between the key front end, the engine and the renderer.
interface c4_board_engine_if;
   import c4_pkg::*;

   logic       drop_req;
   logic [2:0] col_sel;
   logic       new_game;
   logic [1:0] board [NCELLS];
   logic       p2_turn;
   logic       busy;
   logic       illegal;
   logic       game_over;
   logic [1:0] winner;

   modport master (
      output drop_req, col_sel, new_game,
      input  board, p2_turn, busy, illegal, game_over, winner
   );

   modport slave (
      input  drop_req, col_sel, new_game,
      output board, p2_turn, busy, illegal, game_over, winner
   );

endinterface

// File: rtl/c4_gap_timer.sv
// One-shot gap timer: done pulses HOLD_CYCLES cycles after a start pulse.
module c4_gap_timer #(
   parameter int HOLD_CYCLES = 65536
) (
   input  logic CLOCK_50,
   input  logic Resetn,
   input  logic start,
   output logic done
);

   localparam int CW = $clog2(HOLD_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

   logic [CW-1:0] cnt_reg;
   logic          run_reg;

   assign done = run_reg && (cnt_reg == LAST);

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         cnt_reg <= '0;
         run_reg <= 1'b0;
      end else if (start) begin
         cnt_reg <= '0;
         run_reg <= 1'b1;
      end else if (done) begin
         run_reg <= 1'b0;
      end else if (run_reg) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/c4_board_engine.sv
// Connect-4 game-state engine: column drops, landing search, win check, turn order and
// paced board clear, with at most one cell changing per hold window.
module c4_board_engine
   import c4_pkg::*;
#(
   parameter int HOLD_CYCLES = 65536,
   parameter int WIN_LEN     = 4
) (
   input logic              CLOCK_50,
   input logic              Resetn,
   c4_board_engine_if.slave bus
);

   localparam logic [3:0] WL4 = 4'(WIN_LEN);

   state_t     state_reg, state_next;
   logic [1:0] board_reg [NCELLS];
   logic       board_we;
   logic [5:0] board_widx;
   logic [1:0] board_wdata;

   logic       drop_cur_reg, drop_prev_reg, ng_cur_reg, ng_prev_reg;
   logic [2:0] col_reg, col_next, row_reg, row_next;
   logic       p2_turn_reg, p2_turn_next;
   logic [5:0] move_cnt_reg, move_cnt_next, clr_idx_reg, clr_idx_next;
   logic       illegal_reg, illegal_next, game_over_reg, game_over_next;
   logic       win_reg, win_next, side_reg, side_next;
   logic [1:0] winner_reg, winner_next, dir_reg, dir_next, dir_inc;
   logic [3:0] steps_reg, steps_next, count_reg, count_next;
   coord_t     chk_r_reg, chk_r_next, chk_c_reg, chk_c_next;
   coord_t     row_c, col_c, step_r, step_c;

   logic       drop_edge, ng_edge, gap_start, gap_done, end_side, probe_hit;
   logic [1:0] mover;
   logic [5:0] find_idx, probe_idx;

   assign drop_edge = drop_cur_reg & ~drop_prev_reg;
   assign ng_edge   = ng_cur_reg & ~ng_prev_reg;
   assign mover     = p2_turn_reg ? CELL_P2 : CELL_P1;
   assign row_c     = coord_t'({1'b0, row_reg});
   assign col_c     = coord_t'({1'b0, col_reg});
   assign dir_inc   = dir_reg + 2'd1;
   assign step_r    = side_reg ? -dir_dr(dir_reg) : dir_dr(dir_reg);
   assign step_c    = side_reg ? -dir_dc(dir_reg) : dir_dc(dir_reg);
   assign find_idx  = cell_idx(row_reg, col_reg);
   assign probe_idx = cell_idx(chk_r_reg[2:0], chk_c_reg[2:0]);
   assign probe_hit = on_board(chk_r_reg, chk_c_reg) && (board_reg[probe_idx] == mover);

   // The timer restarts on every entry into a gap state, so HOLD and CLR_HOLD share it.
   assign gap_start = ((state_next == S_HOLD) || (state_next == S_CLR_HOLD)) &&
                      (state_next != state_reg);

   c4_gap_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_gap_timer (
      .CLOCK_50 (CLOCK_50),
      .Resetn   (Resetn),
      .start    (gap_start),
      .done     (gap_done)
   );

   always_comb begin
      state_next     = state_reg;
      col_next       = col_reg;
      row_next       = row_reg;
      p2_turn_next   = p2_turn_reg;
      move_cnt_next  = move_cnt_reg;
      clr_idx_next   = clr_idx_reg;
      illegal_next   = 1'b0;
      game_over_next = game_over_reg;
      win_next       = win_reg;
      winner_next    = winner_reg;
      dir_next       = dir_reg;
      side_next      = side_reg;
      steps_next     = steps_reg;
      count_next     = count_reg;
      chk_r_next     = chk_r_reg;
      chk_c_next     = chk_c_reg;
      board_we       = 1'b0;
      board_widx     = find_idx;
      board_wdata    = mover;
      end_side       = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (ng_edge) begin
               clr_idx_next = 6'd0;
               state_next   = S_CLEAR;
            end else if (drop_edge) begin
               if (bus.col_sel > 3'd6) begin
                  illegal_next = 1'b1;
               end else begin
                  col_next   = bus.col_sel;
                  row_next   = 3'd5;
                  state_next = S_FIND;
               end
            end
         end
         S_FIND: begin
            if (board_reg[find_idx] == CELL_EMPTY) begin
               state_next = S_PLACE;
            end else if (row_reg == 3'd0) begin
               illegal_next = 1'b1;
               state_next   = S_IDLE;
            end else begin
               row_next = row_reg - 3'd1;
            end
         end
         S_PLACE: begin
            board_we      = 1'b1;
            move_cnt_next = move_cnt_reg + 6'd1;
            win_next      = 1'b0;
            dir_next      = 2'd0;
            side_next     = 1'b0;
            steps_next    = 4'd0;
            count_next    = 4'd1;
            chk_r_next    = row_c + dir_dr(2'd0);
            chk_c_next    = col_c + dir_dc(2'd0);
            state_next    = S_CHECK;
         end
         S_CHECK: begin
            // One probe per cycle; a side ends at the board edge, a foreign cell or the step limit.
            if (probe_hit) begin
               if (count_reg + 4'd1 >= WL4) begin
                  win_next    = 1'b1;
                  winner_next = mover;
                  state_next  = S_HOLD;
               end else begin
                  count_next = count_reg + 4'd1;
                  steps_next = steps_reg + 4'd1;
                  if (steps_reg + 4'd1 < WL4 - 4'd1) begin
                     chk_r_next = chk_r_reg + step_r;
                     chk_c_next = chk_c_reg + step_c;
                  end else begin
                     end_side = 1'b1;
                  end
               end
            end else begin
               end_side = 1'b1;
            end
            if (end_side) begin
               steps_next = 4'd0;
               if (!side_reg) begin
                  side_next  = 1'b1;
                  chk_r_next = row_c - dir_dr(dir_reg);
                  chk_c_next = col_c - dir_dc(dir_reg);
               end else if (dir_reg == 2'd3) begin
                  state_next = S_HOLD;
               end else begin
                  dir_next   = dir_inc;
                  side_next  = 1'b0;
                  count_next = 4'd1;
                  chk_r_next = row_c + dir_dr(dir_inc);
                  chk_c_next = col_c + dir_dc(dir_inc);
               end
            end
         end
         S_HOLD: begin
            if (gap_done) begin
               if (win_reg) begin
                  game_over_next = 1'b1;
                  state_next     = S_OVER;
               end else if (move_cnt_reg == 6'd42) begin
                  game_over_next = 1'b1;
                  winner_next    = WIN_DRAW;
                  state_next     = S_OVER;
               end else begin
                  p2_turn_next = ~p2_turn_reg;
                  state_next   = S_IDLE;
               end
            end
         end
         S_OVER: begin
            if (ng_edge) begin
               clr_idx_next = 6'd0;
               state_next   = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (board_reg[clr_idx_reg] != CELL_EMPTY) begin
               board_we    = 1'b1;
               board_widx  = clr_idx_reg;
               board_wdata = CELL_EMPTY;
               state_next  = S_CLR_HOLD;
            end else if (clr_idx_reg == 6'd41) begin
               state_next = S_IDLE;
            end else begin
               clr_idx_next = clr_idx_reg + 6'd1;
            end
         end
         S_CLR_HOLD: begin
            if (gap_done) begin
               if (clr_idx_reg == 6'd41) begin
                  state_next = S_IDLE;
               end else begin
                  clr_idx_next = clr_idx_reg + 6'd1;
                  state_next   = S_CLEAR;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase

      // Leaving the clear scan restores a fresh game.
      if ((state_reg == S_CLEAR || state_reg == S_CLR_HOLD) && state_next == S_IDLE) begin
         p2_turn_next   = 1'b0;
         winner_next    = WIN_NONE;
         game_over_next = 1'b0;
         move_cnt_next  = 6'd0;
         win_next       = 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state_reg     <= S_IDLE;
         drop_cur_reg  <= 1'b0;
         drop_prev_reg <= 1'b0;
         ng_cur_reg    <= 1'b0;
         ng_prev_reg   <= 1'b0;
         col_reg       <= 3'd0;
         row_reg       <= 3'd0;
         p2_turn_reg   <= 1'b0;
         move_cnt_reg  <= 6'd0;
         clr_idx_reg   <= 6'd0;
         illegal_reg   <= 1'b0;
         game_over_reg <= 1'b0;
         win_reg       <= 1'b0;
         winner_reg    <= WIN_NONE;
         dir_reg       <= 2'd0;
         side_reg      <= 1'b0;
         steps_reg     <= 4'd0;
         count_reg     <= 4'd0;
         chk_r_reg     <= 4'sd0;
         chk_c_reg     <= 4'sd0;
      end else begin
         state_reg     <= state_next;
         drop_cur_reg  <= bus.drop_req;
         drop_prev_reg <= drop_cur_reg;
         ng_cur_reg    <= bus.new_game;
         ng_prev_reg   <= ng_cur_reg;
         col_reg       <= col_next;
         row_reg       <= row_next;
         p2_turn_reg   <= p2_turn_next;
         move_cnt_reg  <= move_cnt_next;
         clr_idx_reg   <= clr_idx_next;
         illegal_reg   <= illegal_next;
         game_over_reg <= game_over_next;
         win_reg       <= win_next;
         winner_reg    <= winner_next;
         dir_reg       <= dir_next;
         side_reg      <= side_next;
         steps_reg     <= steps_next;
         count_reg     <= count_next;
         chk_r_reg     <= chk_r_next;
         chk_c_reg     <= chk_c_next;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < NCELLS; i++) board_reg[i] <= CELL_EMPTY;
      end else if (board_we) begin
         board_reg[board_widx] <= board_wdata;
      end
   end

   generate
      for (genvar gi = 0; gi < NCELLS; gi++) begin : g_board_out
         assign bus.board[gi] = board_reg[gi];
      end
   endgenerate

   assign bus.p2_turn   = p2_turn_reg;
   assign bus.busy      = !((state_reg == S_IDLE) || (state_reg == S_OVER));
   assign bus.illegal   = illegal_reg;
   assign bus.game_over = game_over_reg;
   assign bus.winner    = winner_reg;

endmodule
